music_player_ctrl: RTL and testbench

//  Sequences the beat-indexed tone ROM (Music): generates beat_num at a fixed quarter-beat

---
 rtl/music_player_ctrl.sv | 131 +++++++++++++
 tb/tb_music_player_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/music_player_ctrl.sv
// music_player_ctrl: quarter-beat sequencer for the tone ROM with start/pause/stop and horn override.
// Define MUSIC_LOOP_EN to wrap the song back to beat 0 instead of ending with a done pulse.
module music_player_ctrl #(
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned BEAT_HZ   = 8,
   parameter logic [7:0]  LAST_BEAT = 8'd71,
   parameter logic [31:0] HORN_FREQ = 32'd880,
   parameter logic [31:0] SILENCE   = 32'd20000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        pause,
   input  logic        stop,
   input  logic        horn,
   input  logic [31:0] tone_in,
   output logic [7:0]  beat_num,
   output logic [31:0] freq_out,
   output logic [1:0]  state_o,
   output logic        done
);

   localparam int unsigned TICK_DIV = CLK_FREQ / BEAT_HZ;
   localparam int unsigned TICK_W   = $clog2(TICK_DIV);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_PLAY  = 2'b01,
      S_PAUSE = 2'b10,
      S_HORN  = 2'b11
   } state_t;

   state_t              state, state_nxt;
   state_t              saved, saved_nxt;
   logic [TICK_W-1:0]   tick_cnt, tick_nxt;
   logic [7:0]          beat_nxt;
   logic [31:0]         freq_nxt;
   logic                end_song;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         saved    <= S_IDLE;
         tick_cnt <= '0;
         beat_num <= '0;
         freq_out <= SILENCE;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         saved    <= saved_nxt;
         tick_cnt <= tick_nxt;
         beat_num <= beat_nxt;
         freq_out <= freq_nxt;
         done     <= end_song;
      end
   end

   // Horn preempts every music state; the interrupted state is restored when it drops.
   always_comb begin
      state_nxt = state;
      saved_nxt = saved;
      tick_nxt  = tick_cnt;
      beat_nxt  = beat_num;
      end_song  = 1'b0;
      if (state != S_HORN && horn) begin
         state_nxt = S_HORN;
         saved_nxt = state;
      end else if (state == S_HORN) begin
         if (!horn)
            state_nxt = saved;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state_nxt = S_PLAY;
                  tick_nxt  = '0;
                  beat_nxt  = '0;
               end
            end
            S_PLAY: begin
               if (stop) begin
                  state_nxt = S_IDLE;
                  tick_nxt  = '0;
                  beat_nxt  = '0;
               end else if (pause) begin
                  state_nxt = S_PAUSE;
               end else if (tick_cnt == TICK_LAST) begin
                  tick_nxt = '0;
                  if (beat_num == LAST_BEAT) begin
                     beat_nxt = '0;
`ifdef MUSIC_LOOP_EN
                     state_nxt = S_PLAY;
`else
                     state_nxt = S_IDLE;
                     end_song  = 1'b1;
`endif
                  end else begin
                     beat_nxt = beat_num + 8'd1;
                  end
               end else begin
                  tick_nxt = tick_cnt + 1'b1;
               end
            end
            S_PAUSE: begin
               if (stop) begin
                  state_nxt = S_IDLE;
                  tick_nxt  = '0;
                  beat_nxt  = '0;
               end else if (start) begin
                  state_nxt = S_PLAY;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Frequency follows the next state so horn entry/exit switch the tone on the same edge.
   always_comb begin
      freq_nxt = SILENCE;
      case (state_nxt)
         S_PLAY:  freq_nxt = tone_in;
         S_HORN:  freq_nxt = HORN_FREQ;
         default: freq_nxt = SILENCE;
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_music_player_ctrl.sv
// Scoreboard bench for music_player_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_music_player_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, pause, stop, horn;
   logic [31:0] tone_in;
   logic [7:0]  beat_num;
   logic [31:0] freq_out;
   logic [1:0]  state_o;
   logic        done;

   always #5 clk = ~clk;

   music_player_ctrl #(
      .CLK_FREQ (16),
      .BEAT_HZ  (4),
      .LAST_BEAT(8'd3),
      .HORN_FREQ(32'd880),
      .SILENCE  (32'd20000)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .pause   (pause),
      .stop    (stop),
      .horn    (horn),
      .tone_in (tone_in),
      .beat_num(beat_num),
      .freq_out(freq_out),
      .state_o (state_o),
      .done    (done)
   );

   // Tone ROM stand-in
   always_comb begin
      case (beat_num)
         8'd0:    tone_in = 32'd1044;
         8'd1:    tone_in = 32'd986;
         8'd2:    tone_in = 32'd1318;
         8'd3:    tone_in = 32'd1175;
         default: tone_in = 32'd0;
      endcase
   end

   typedef struct {
      int          cyc;
      string       name;
      logic [1:0]  st;
      logic [7:0]  bn;
      logic [31:0] fr;
      logic        dn;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         vectors++;
         if (mon_e.cyc != cyc) begin
            miscompares++;
            $display("FAIL %s: check due at cycle %0d missed (now %0d)", mon_e.name, mon_e.cyc, cyc);
         end else if (state_o !== mon_e.st || beat_num !== mon_e.bn ||
                      freq_out !== mon_e.fr || done !== mon_e.dn) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got state=%b beat=%0d freq=%0d done=%b, required state=%b beat=%0d freq=%0d done=%b",
                     mon_e.name, cyc, state_o, beat_num, freq_out, done,
                     mon_e.st, mon_e.bn, mon_e.fr, mon_e.dn);
         end
      end
   end

   task automatic push_exp(input int t, input string nm, input logic [1:0] st,
                           input logic [7:0] bn, input logic [31:0] fr, input logic dn);
      exp_t e;
      e.cyc = t; e.name = nm; e.st = st; e.bn = bn; e.fr = fr; e.dn = dn;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; step(); stop = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int b;
      rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; horn = 1'b0;

      // reset and idle
      push_exp(1, "reset_1", 2'b00, 8'd0, 32'd20000, 1'b0);
      push_exp(2, "reset_2", 2'b00, 8'd0, 32'd20000, 1'b0);
      run(2);
      rst = 1'b0;
      b = cyc;
      push_exp(b + 1,  "idle_1",  2'b00, 8'd0, 32'd20000, 1'b0);
      push_exp(b + 10, "idle_10", 2'b00, 8'd0, 32'd20000, 1'b0);
      run(10);

      // start, beat progression and end of song
      b = cyc;
      push_exp(b + 2,  "play_first_tone", 2'b01, 8'd0, 32'd1044, 1'b0);
      push_exp(b + 5,  "beat1_index",     2'b01, 8'd1, 32'd1044, 1'b0);
      push_exp(b + 6,  "beat1_tone",      2'b01, 8'd1, 32'd986,  1'b0);
      push_exp(b + 10, "beat2_tone",      2'b01, 8'd2, 32'd1318, 1'b0);
      push_exp(b + 16, "last_beat",       2'b01, 8'd3, 32'd1175, 1'b0);
`ifdef MUSIC_LOOP_EN
      push_exp(b + 17, "loop_wrap",       2'b01, 8'd0, 32'd1175, 1'b0);
      push_exp(b + 18, "loop_tone",       2'b01, 8'd0, 32'd1044, 1'b0);
`else
      push_exp(b + 17, "song_end",        2'b00, 8'd0, 32'd20000, 1'b1);
      push_exp(b + 18, "done_one_cycle",  2'b00, 8'd0, 32'd20000, 1'b0);
`endif
      push_exp(b + 19, "stop_to_idle",    2'b00, 8'd0, 32'd20000, 1'b0);
      pulse_start();
      run(17);
      pulse_stop();

      // pause at beat 2 with tick_cnt=1, resume finishes the remaining ticks
      b = cyc;
      push_exp(b + 10, "pre_pause",      2'b01, 8'd2, 32'd1318,  1'b0);
      push_exp(b + 11, "paused",         2'b10, 8'd2, 32'd20000, 1'b0);
      push_exp(b + 31, "paused_20",      2'b10, 8'd2, 32'd20000, 1'b0);
      push_exp(b + 32, "resumed",        2'b01, 8'd2, 32'd1318,  1'b0);
      push_exp(b + 34, "resume_no_tick", 2'b01, 8'd2, 32'd1318,  1'b0);
      push_exp(b + 35, "resume_beat3",   2'b01, 8'd3, 32'd1318,  1'b0);
      push_exp(b + 36, "resume_tone3",   2'b01, 8'd3, 32'd1175,  1'b0);
      push_exp(b + 37, "pause_stop",     2'b00, 8'd0, 32'd20000, 1'b0);
      pulse_start();
      run(9);
      pause = 1'b1; step(); pause = 1'b0;
      run(20);
      pulse_start();
      run(4);
      pulse_stop();

      // horn from idle
      b = cyc;
      push_exp(b + 1, "horn_from_idle", 2'b11, 8'd0, 32'd880,   1'b0);
      push_exp(b + 2, "horn_back_idle", 2'b00, 8'd0, 32'd20000, 1'b0);
      horn = 1'b1; step();
      horn = 1'b0; step();

      // horn during play at beat 1, start/stop pulses dropped
      b = cyc;
      push_exp(b + 7,  "horn_enter",     2'b11, 8'd1, 32'd880,  1'b0);
      push_exp(b + 12, "horn_hold",      2'b11, 8'd1, 32'd880,  1'b0);
      push_exp(b + 13, "horn_exit",      2'b01, 8'd1, 32'd986,  1'b0);
      push_exp(b + 15, "horn_tick_kept", 2'b01, 8'd1, 32'd986,  1'b0);
      push_exp(b + 16, "horn_beat2",     2'b01, 8'd2, 32'd986,  1'b0);
      push_exp(b + 17, "horn_tone2",     2'b01, 8'd2, 32'd1318, 1'b0);
      push_exp(b + 18, "horn_stop",      2'b00, 8'd0, 32'd20000, 1'b0);
      pulse_start();
      run(5);
      horn = 1'b1; step();
      step();
      pulse_start();
      step();
      pulse_stop();
      step();
      horn = 1'b0; step();
      run(4);
      pulse_stop();

      // stop on the final beat tick wins over end of song
      b = cyc;
      push_exp(b + 16, "pre_final",     2'b01, 8'd3, 32'd1175,  1'b0);
      push_exp(b + 17, "stop_vs_final", 2'b00, 8'd0, 32'd20000, 1'b0);
      push_exp(b + 18, "no_done",       2'b00, 8'd0, 32'd20000, 1'b0);
      pulse_start();
      run(15);
      pulse_stop();
      step();

      // reset while in horn, then a clean restart
      b = cyc;
      push_exp(b + 8,  "horn_before_rst", 2'b11, 8'd1, 32'd880,   1'b0);
      push_exp(b + 9,  "rst_in_horn",     2'b00, 8'd0, 32'd20000, 1'b0);
      push_exp(b + 10, "post_rst_idle",   2'b00, 8'd0, 32'd20000, 1'b0);
      push_exp(b + 14, "restart_beat0",   2'b01, 8'd0, 32'd1044,  1'b0);
      push_exp(b + 15, "restart_beat1",   2'b01, 8'd1, 32'd1044,  1'b0);
      push_exp(b + 17, "restart_stop",    2'b00, 8'd0, 32'd20000, 1'b0);
      pulse_start();
      run(5);
      horn = 1'b1; run(2);
      rst = 1'b1; step();
      rst = 1'b0; horn = 1'b0; step();
      pulse_start();
      run(5);
      pulse_stop();

      run(3);
      if (sb.size() != 0) begin
         miscompares += sb.size();
         $display("FAIL scoreboard_drain: %0d checks left, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
